// File: rtl/serial_adder_pkg.sv
// Shared types and operation encoding for the bit-serial add/subtract controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_from_half.sv
// One-bit full adder composed of two half-adder stages plus a carry merge.
module full_adder_from_half (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1, c1, c2;

  always_comb begin
    s1   = a ^ b;
    c1   = a & b;
    sum  = s1 ^ cin;
    c2   = s1 & cin;
    cout = c1 | c2;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder cell stepped LSB-first over
// WIDTH cycles, with valid/ready handshakes on operands and result.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum, fa_cout;

  full_adder_from_half u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_sr_d  = op_a;
          b_sr_d  = (sub == OP_SUB) ? ~op_b : op_b;
          c_d     = (sub == OP_SUB) ? 1'b1 : cin;
          cnt_d   = '0;
          r_sr_d  = '0;
        end
      end
      RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d = {fa_sum, r_sr_q[WIDTH-1:1]};
        c_d    = fa_cout;
        // On the MSB step c_q is still the carry into the MSB, which feeds overflow.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = {fa_sum, r_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = c_q ^ fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
